// File: rtl/ibis_texture_layer_scheduler.sv
// Time-multiplexes one 10-phase ibis texture mapper across LAYERS layers and
// queues per-layer results in a 2-entry valid/ready FIFO.
module ibis_texture_layer_scheduler #(
  parameter int LAYERS             = 4,
  parameter int WIDTH              = 11,
  parameter int TILE_SIZE_POW2_MAX = 9,
  localparam int LW = $clog2(LAYERS),
  localparam int AW = 2 * TILE_SIZE_POW2_MAX
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [WIDTH-1:0] pix_x,
  input  logic [WIDTH-1:0] pix_y,
  input  logic             cfg_we,
  input  logic [LW-1:0]    cfg_layer,
  input  logic [2:0]       cfg_sel,
  input  logic [17:0]      cfg_data,
  output logic             tm_enable,
  output logic [6:0]       tm_write_registers,
  output logic [WIDTH-1:0] tm_x,
  output logic [WIDTH-1:0] tm_y,
  output logic [2:0]       tm_power2,
  output logic [17:0]      tm_matrixA,
  output logic [17:0]      tm_matrixB,
  output logic [17:0]      tm_matrixC,
  output logic [17:0]      tm_matrixD,
  output logic [17:0]      tm_translateX,
  output logic [17:0]      tm_translateY,
  input  logic [AW-1:0]    tm_map_address,
  input  logic             tm_stencil_test,
  input  logic             tm_stencil_step,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    out_layer,
  output logic [AW-1:0]    out_address,
  output logic             out_stencil_test,
  output logic             out_stencil_step,
  output logic             out_last
);
  localparam int FW = LW + AW + 3;

  logic [3:0]                   ph_q, ph_d;
  logic                         busy_q, busy_d;
  logic [LAYERS-1:0]            rem_q, rem_d, en_q, en_d;
  logic [WIDTH-1:0]             x_q, x_d, y_q, y_d, hx_q, hx_d, hy_q, hy_d;
  logic [LAYERS-1:0][5:0][17:0] mat_q, mat_d;
  logic [LAYERS-1:0][2:0]       p2_q, p2_d;
  logic [5:0][17:0]             hmat_q, hmat_d;
  logic [2:0]                   hp2_q, hp2_d;
  logic [LW-1:0]                play_q, play_d;
  logic                         plast_q, plast_d;
  logic [1:0][FW-1:0]           fifo_q, fifo_d;
  logic                         wp_q, wp_d, rp_q, rp_d;
  logic [1:0]                   cnt_q, cnt_d;

  logic              ph_zero, stall, pop, acc, issue, capture;
  logic [LAYERS-1:0] imask, nmask;
  logic [LW-1:0]     ilayer;
  logic [WIDTH-1:0]  cur_x, cur_y;

  // Control and mapper-facing outputs; tm_* fall back to the values latched at issue.
  always_comb begin
    ph_zero   = (ph_q == 4'd0);
    out_valid = aresetn && (cnt_q != 2'd0);
    pop       = out_valid && out_ready;
    stall     = ph_zero && busy_q && (cnt_q == 2'd2) && !pop;
    pix_ready = aresetn && ph_zero && (rem_q == '0) && !stall;
    acc       = pix_ready && pix_valid;
    imask     = acc ? en_q : rem_q;
    ilayer    = '0;
    for (int i = LAYERS - 1; i >= 0; i--)
      if (imask[i]) ilayer = LW'(i);
    nmask         = imask;
    nmask[ilayer] = 1'b0;
    issue     = aresetn && ph_zero && !stall && (imask != '0);
    capture   = aresetn && ph_zero && busy_q && !stall;
    tm_enable = aresetn && !(ph_zero && (stall || (!busy_q && !issue)));
    tm_write_registers = issue ? 7'h7F : 7'h00;
    cur_x = acc ? pix_x : x_q;
    cur_y = acc ? pix_y : y_q;
    tm_x          = issue ? cur_x : hx_q;
    tm_y          = issue ? cur_y : hy_q;
    tm_matrixA    = issue ? mat_q[ilayer][0] : hmat_q[0];
    tm_matrixB    = issue ? mat_q[ilayer][1] : hmat_q[1];
    tm_matrixC    = issue ? mat_q[ilayer][2] : hmat_q[2];
    tm_matrixD    = issue ? mat_q[ilayer][3] : hmat_q[3];
    tm_translateX = issue ? mat_q[ilayer][4] : hmat_q[4];
    tm_translateY = issue ? mat_q[ilayer][5] : hmat_q[5];
    tm_power2     = issue ? p2_q[ilayer] : hp2_q;
    {out_layer, out_address, out_stencil_test, out_stencil_step, out_last} = fifo_q[rp_q];
  end

  always_comb begin
    ph_d = ph_q;
    if (tm_enable) ph_d = (ph_q == 4'd9) ? 4'd0 : ph_q + 4'd1;
    busy_d = busy_q;
    if (ph_zero && tm_enable) busy_d = issue;
    rem_d = rem_q;
    if (issue)    rem_d = nmask;
    else if (acc) rem_d = '0;
    x_d     = cur_x;
    y_d     = cur_y;
    hx_d    = tm_x;
    hy_d    = tm_y;
    hmat_d  = {tm_translateY, tm_translateX, tm_matrixD, tm_matrixC, tm_matrixB, tm_matrixA};
    hp2_d   = tm_power2;
    play_d  = issue ? ilayer : play_q;
    plast_d = issue ? (nmask == '0) : plast_q;
    mat_d = mat_q;
    p2_d  = p2_q;
    en_d  = en_q;
    if (cfg_we) begin
      if (cfg_sel < 3'd6)       mat_d[cfg_layer][cfg_sel] = cfg_data;
      else if (cfg_sel == 3'd6) p2_d[cfg_layer] = cfg_data[2:0];
      else                      en_d[cfg_layer] = cfg_data[0];
    end
    // Push into the slot being popped is safe when full: the head is read this cycle.
    fifo_d = fifo_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (capture) begin
      fifo_d[wp_q] = {play_q, tm_map_address, tm_stencil_test, tm_stencil_step, plast_q};
      wp_d = ~wp_q;
    end
    if (pop) rp_d = ~rp_q;
    cnt_d = cnt_q + 2'(capture) - 2'(pop);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ph_q    <= '0;
      busy_q  <= 1'b0;
      rem_q   <= '0;
      en_q    <= LAYERS'(1);
      x_q     <= '0;
      y_q     <= '0;
      hx_q    <= '0;
      hy_q    <= '0;
      hmat_q  <= '0;
      hp2_q   <= '0;
      play_q  <= '0;
      plast_q <= 1'b0;
      fifo_q  <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= '0;
      for (int l = 0; l < LAYERS; l++) begin
        mat_q[l] <= {18'h0, 18'h0, 18'h00100, 18'h0, 18'h0, 18'h00100};
        p2_q[l]  <= 3'd4;
      end
    end else begin
      ph_q    <= ph_d;
      busy_q  <= busy_d;
      rem_q   <= rem_d;
      en_q    <= en_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      hmat_q  <= hmat_d;
      hp2_q   <= hp2_d;
      play_q  <= play_d;
      plast_q <= plast_d;
      fifo_q  <= fifo_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      mat_q   <= mat_d;
      p2_q    <= p2_d;
    end
  end
endmodule

// File: tb/tb_ibis_texture_layer_scheduler.sv
// Bench for ibis_texture_layer_scheduler: behavioural mapper stand-in plus a
// per-pixel job model (layers expanded in ascending order) checked at each issue/result.
module tb_ibis_texture_layer_scheduler;
  logic        aclk = 1'b0;
  logic        aresetn, pix_valid, pix_ready, cfg_we, out_valid, out_ready;
  logic [10:0] pix_x, pix_y, tm_x, tm_y;
  logic [1:0]  cfg_layer, out_layer;
  logic [2:0]  cfg_sel, tm_power2;
  logic [17:0] cfg_data, tm_matrixA, tm_matrixB, tm_matrixC, tm_matrixD;
  logic [17:0] tm_translateX, tm_translateY, tm_map_address, out_address;
  logic        tm_enable, tm_stencil_test, tm_stencil_step;
  logic        out_stencil_test, out_stencil_step, out_last;
  logic [6:0]  tm_write_registers;

  always #5 aclk = ~aclk;

  ibis_texture_layer_scheduler dut (
    .aclk(aclk), .aresetn(aresetn), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .tm_enable(tm_enable),
    .tm_write_registers(tm_write_registers), .tm_x(tm_x), .tm_y(tm_y),
    .tm_power2(tm_power2), .tm_matrixA(tm_matrixA), .tm_matrixB(tm_matrixB),
    .tm_matrixC(tm_matrixC), .tm_matrixD(tm_matrixD), .tm_translateX(tm_translateX),
    .tm_translateY(tm_translateY), .tm_map_address(tm_map_address),
    .tm_stencil_test(tm_stencil_test), .tm_stencil_step(tm_stencil_step),
    .out_valid(out_valid), .out_ready(out_ready), .out_layer(out_layer),
    .out_address(out_address), .out_stencil_test(out_stencil_test),
    .out_stencil_step(out_stencil_step), .out_last(out_last)
  );

  function automatic logic [17:0] fmap(input logic [10:0] x, y,
                                       input logic [17:0] a, b, c, d, tx, ty,
                                       input logic [2:0] p2);
    logic [35:0] u, v;
    u = 36'(x) * 36'(a) + 36'(y) * 36'(b) + 36'(tx);
    v = 36'(x) * 36'(c) + 36'(y) * 36'(d) + 36'(ty);
    return u[17:0] ^ v[20:3] ^ {15'd0, p2};
  endfunction

  // Mapper stand-in: latches a frame's parameters when written, result held until the next write.
  logic [10:0] m_x = '0, m_y = '0;
  logic [17:0] m_a = '0, m_b = '0, m_c = '0, m_d = '0, m_tx = '0, m_ty = '0;
  logic [2:0]  m_p2 = '0;
  always @(posedge aclk)
    if (tm_enable && tm_write_registers == 7'h7F) begin
      m_x <= tm_x; m_y <= tm_y; m_a <= tm_matrixA; m_b <= tm_matrixB; m_c <= tm_matrixC;
      m_d <= tm_matrixD; m_tx <= tm_translateX; m_ty <= tm_translateY; m_p2 <= tm_power2;
    end
  assign tm_map_address  = fmap(m_x, m_y, m_a, m_b, m_c, m_d, m_tx, m_ty, m_p2);
  assign tm_stencil_test = ^tm_map_address;
  assign tm_stencil_step = m_x[0] ^ m_y[1];

  typedef struct {
    logic [1:0]  layer;
    logic [10:0] x, y;
    logic [17:0] a, b, c, d, tx, ty;
    logic [2:0]  p2;
    logic        last;
  } job_t;

  job_t        iq[$], oq[$];
  logic [17:0] mcfg[4][6];
  logic [2:0]  mp2[4];
  logic [3:0]  men;
  int vec = 0, errs = 0, cyc_n = 0, acc_cyc = 0, first_valid = -1, n_pop = 0;
  logic        mon_acc = 1'b0;
  logic [17:0] mon_a = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      mcfg[l][0] = 18'h00100; mcfg[l][1] = '0; mcfg[l][2] = '0;
      mcfg[l][3] = 18'h00100; mcfg[l][4] = '0; mcfg[l][5] = '0;
      mp2[l] = 3'd4;
    end
    men = 4'b0001;
    iq.delete();
    oq.delete();
  endtask

  task automatic push_jobs(input logic [10:0] x, y);
    job_t j;
    int hi = -1;
    for (int i = 0; i < 4; i++) if (men[i]) hi = i;
    for (int i = 0; i < 4; i++)
      if (men[i]) begin
        j.layer = 2'(i); j.x = x; j.y = y;
        j.a = mcfg[i][0]; j.b = mcfg[i][1]; j.c = mcfg[i][2]; j.d = mcfg[i][3];
        j.tx = mcfg[i][4]; j.ty = mcfg[i][5]; j.p2 = mp2[i]; j.last = (i == hi);
        iq.push_back(j);
        oq.push_back(j);
      end
  endtask

  task automatic monitor();
    job_t j;
    logic [17:0] ea;
    cyc_n++;
    mon_acc = 1'b0;
    if (aresetn) begin
      if (pix_valid && pix_ready) begin
        mon_acc = 1'b1;
        acc_cyc = cyc_n;
        push_jobs(pix_x, pix_y);
      end
      if (tm_write_registers != 7'h00) begin
        chk("issue_expected", 64'(iq.size() != 0), 64'(1));
        if (iq.size() != 0) begin
          j = iq.pop_front();
          mon_a = tm_matrixA;
          chk("iss_wr", 64'(tm_write_registers), 64'h7F);
          chk("iss_en", 64'(tm_enable), 64'(1));
          chk("iss_x", 64'(tm_x), 64'(j.x));
          chk("iss_y", 64'(tm_y), 64'(j.y));
          chk("iss_A", 64'(tm_matrixA), 64'(j.a));
          chk("iss_B", 64'(tm_matrixB), 64'(j.b));
          chk("iss_C", 64'(tm_matrixC), 64'(j.c));
          chk("iss_D", 64'(tm_matrixD), 64'(j.d));
          chk("iss_Tx", 64'(tm_translateX), 64'(j.tx));
          chk("iss_Ty", 64'(tm_translateY), 64'(j.ty));
          chk("iss_p2", 64'(tm_power2), 64'(j.p2));
        end
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc_n;
        chk("out_expected", 64'(oq.size() != 0), 64'(1));
        if (oq.size() != 0) begin
          j = oq[0];
          ea = fmap(j.x, j.y, j.a, j.b, j.c, j.d, j.tx, j.ty, j.p2);
          chk("out_layer", 64'(out_layer), 64'(j.layer));
          chk("out_address", 64'(out_address), 64'(ea));
          chk("out_st_test", 64'(out_stencil_test), 64'(^ea));
          chk("out_st_step", 64'(out_stencil_step), 64'(j.x[0] ^ j.y[1]));
          chk("out_last", 64'(out_last), 64'(j.last));
          if (out_ready) begin
            void'(oq.pop_front());
            n_pop++;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    #1;
    monitor();
    @(posedge aclk);
    #1;
  endtask

  task automatic cfg_wr(input int l, input int s, input logic [17:0] d);
    cfg_we = 1'b1; cfg_layer = 2'(l); cfg_sel = 3'(s); cfg_data = d;
    cyc();
    cfg_we = 1'b0;
    if (s < 6) mcfg[l][s] = d;
    else if (s == 6) mp2[l] = d[2:0];
    else men[l] = d[0];
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!pix_ready && n < 40) begin cyc(); n++; end
    chk(tag, 64'(pix_ready), 64'(1));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    pix_valid = 1'b0;
    out_ready = 1'b1;
    while ((iq.size() != 0 || oq.size() != 0) && n < 400) begin cyc(); n++; end
    chk(tag, 64'(iq.size() + oq.size()), 64'(0));
  endtask

  task automatic send(input string tag, input logic [10:0] x, y);
    pix_x = x; pix_y = y; pix_valid = 1'b1;
    cyc();
    pix_valid = 1'b0;
    chk(tag, 64'(mon_acc), 64'(1));
  endtask

  initial begin
    int n, p0;
    aresetn = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_layer = '0; cfg_sel = '0; cfg_data = '0;
    model_reset();
    @(posedge aclk);
    #1;
    repeat (3) begin
      cyc();
      chk("rst_pix_ready", 64'(pix_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_tm_enable", 64'(tm_enable), 64'(0));
      chk("rst_wr", 64'(tm_write_registers), 64'(0));
    end
    aresetn = 1'b1;

    // Single pixel, default config, layer 0 only.
    first_valid = -1;
    send("t1_accept", 11'd5, 11'd7);
    chk("t1_default_A", 64'(mon_a), 64'h00100);
    repeat (14) cyc();
    chk("t1_latency", 64'(first_valid - acc_cyc), 64'(11));
    drain("t1_drain");

    // Layers 1 and 3: next pixel slot 20 cycles after accept.
    cfg_wr(0, 7, 18'd0); cfg_wr(1, 7, 18'd1); cfg_wr(3, 7, 18'd1);
    wait_ready("t2_ready");
    send("t2_accept", 11'($urandom), 11'($urandom));
    n = 1;
    while (!pix_ready && n < 40) begin cyc(); n++; end
    chk("t2_next_ready", 64'(n), 64'(20));
    drain("t2_drain");

    // All layers with a blocked consumer: FIFO fills, mapper parks, nothing lost.
    cfg_wr(0, 7, 18'd1); cfg_wr(2, 7, 18'd1);
    wait_ready("t3_ready");
    out_ready = 1'b0;
    p0 = n_pop;
    send("t3_accept", 11'($urandom), 11'($urandom));
    repeat (40) cyc();
    chk("t3_stall_enable", 64'(tm_enable), 64'(0));
    chk("t3_stall_valid", 64'(out_valid), 64'(1));
    chk("t3_stall_ready", 64'(pix_ready), 64'(0));
    drain("t3_drain");
    chk("t3_delivered", 64'(n_pop - p0), 64'(4));

    // Config write to layer 1 while its frame is in flight.
    cfg_wr(0, 7, 18'd0); cfg_wr(2, 7, 18'd0); cfg_wr(3, 7, 18'd0);
    wait_ready("t4_ready");
    send("t4_accept", 11'd100, 11'd200);
    chk("t4_old_A", 64'(mon_a), 64'h00100);
    repeat (3) cyc();
    cfg_wr(1, 0, 18'h00200);
    drain("t4_drain");
    wait_ready("t4_ready2");
    send("t4_accept2", 11'd100, 11'd200);
    chk("t4_new_A", 64'(mon_a), 64'h00200);
    drain("t4_drain2");

    // Reset at ph==5 of a job.
    wait_ready("t5_ready");
    send("t5_accept", 11'($urandom), 11'($urandom));
    repeat (4) cyc();
    aresetn = 1'b0;
    model_reset();
    cyc(); cyc();
    chk("t5_rst_valid", 64'(out_valid), 64'(0));
    aresetn = 1'b1;
    first_valid = -1;
    send("t5_accept_after", 11'($urandom), 11'($urandom));
    repeat (14) cyc();
    chk("t5_latency", 64'(first_valid - acc_cyc), 64'(11));
    drain("t5_drain");

    // Empty mask: pixel accepted, nothing produced.
    for (int l = 0; l < 4; l++) cfg_wr(l, 7, 18'd0);
    wait_ready("t6_ready");
    p0 = n_pop;
    send("t6_accept", 11'd1, 11'd2);
    repeat (25) cyc();
    chk("t6_no_output", 64'(n_pop - p0), 64'(0));

    // Randomized traffic with random config and backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int l = 0; l < 4; l++) begin
        for (int s = 0; s < 6; s++) cfg_wr(l, s, 18'($urandom));
        cfg_wr(l, 6, 18'($urandom_range(0, 7)));
        cfg_wr(l, 7, 18'($urandom_range(0, 1)));
      end
      repeat (400) begin
        pix_valid = 1'($urandom_range(0, 1));
        pix_x = 11'($urandom); pix_y = 11'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        cyc();
      end
      drain("rand_drain");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
